// File: rtl/bsg_scatter_gather_pkg.sv
// Shared types and helpers for the scatter/gather lane packer.
package bsg_scatter_gather_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } sg_state_e;

  // Width needed to hold a lane count in the range 0..lanes.
  function automatic int count_width(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/bsg_compact_lanes.sv
// Combinational lane compactor: packs masked lanes to the bottom in ascending
// order, and reports the popcount and, per output lane, its source lane index.
module bsg_compact_lanes
  import bsg_scatter_gather_pkg::*;
#(
  parameter int lanes_p = 4,
  parameter int width_p = 8,
  localparam int cw_lp = count_width(lanes_p),
  localparam int iw_lp = $clog2(lanes_p)
) (
  input  logic [lanes_p*width_p-1:0] data_i,
  input  logic [lanes_p-1:0]         mask_i,
  output logic [lanes_p*width_p-1:0] data_o,
  output logic [cw_lp-1:0]           count_o,
  output logic [lanes_p*iw_lp-1:0]   src_idx_o
);

  // Running prefix sum of the mask gives each valid lane its output slot.
  always_comb begin
    int pos;
    pos       = 0;
    data_o    = '0;
    src_idx_o = '0;
    for (int i = 0; i < lanes_p; i++) begin
      if (mask_i[i]) begin
        data_o[pos*width_p +: width_p]  = data_i[i*width_p +: width_p];
        src_idx_o[pos*iw_lp +: iw_lp]   = iw_lp'(i);
        pos = pos + 1;
      end
    end
    count_o = cw_lp'(pos);
  end

endmodule

// File: rtl/bsg_scatter_gather_packer.sv
// Streaming lane packer: merges compacted input lanes behind a residue of
// earlier lanes and emits dense beats of lanes_p lanes, flushing at packet end.
//
// state | meaning
// RUN   | accepting input beats
// FLUSH | input stalled; residue left over after a last beat is emitted next
module bsg_scatter_gather_packer
  import bsg_scatter_gather_pkg::*;
#(
  parameter int lanes_p = 4,
  parameter int width_p = 8,
  localparam int cw_lp = count_width(lanes_p),
  localparam int iw_lp = $clog2(lanes_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  output logic                       ready_o,
  input  logic [lanes_p*width_p-1:0] data_i,
  input  logic [lanes_p-1:0]         mask_i,
  input  logic                       last_i,
  output logic                       v_o,
  input  logic                       yumi_i,
  output logic [lanes_p*width_p-1:0] data_o,
  output logic [cw_lp-1:0]           count_o,
  output logic                       last_o
);

  sg_state_e                  state_q, state_n;
  logic [width_p-1:0]         res_q [lanes_p-1];
  logic [cw_lp-1:0]           occ_q;
  logic [lanes_p*width_p-1:0] data_q;
  logic [cw_lp-1:0]           count_q;
  logic                       last_q;
  logic                       v_q;

  logic [lanes_p*width_p-1:0] comp_data;
  logic [cw_lp-1:0]           comp_count;
  logic [lanes_p*iw_lp-1:0]   src_idx;
  logic [width_p-1:0]         merged [2*lanes_p-1];
  logic [lanes_p*width_p-1:0] res_flat;
  int                         total;
  logic                       out_free;
  logic                       accept;
  logic                       flush_emit;

  bsg_compact_lanes #(
    .lanes_p(lanes_p),
    .width_p(width_p)
  ) compact (
    .data_i   (data_i),
    .mask_i   (mask_i),
    .data_o   (comp_data),
    .count_o  (comp_count),
    .src_idx_o(src_idx)
  );

  // Merge residue (oldest) ahead of compacted input; lanes past total stay zero.
  always_comb begin
    int off;
    total = int'(occ_q) + int'(comp_count);
    for (int j = 0; j < 2*lanes_p-1; j++) begin
      off = j - int'(occ_q);
      if (off >= 0 && off < lanes_p) merged[j] = comp_data[off*width_p +: width_p];
      else                           merged[j] = '0;
    end
    for (int j = 0; j < lanes_p-1; j++) begin
      if (j < int'(occ_q)) merged[j] = res_q[j];
    end
    res_flat = '0;
    for (int j = 0; j < lanes_p-1; j++) res_flat[j*width_p +: width_p] = res_q[j];
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= RUN;
    else            state_q <= state_n;
  end

  // Next state: a last beat that overflows leaves residue that needs its own beat.
  always_comb begin
    state_n = state_q;
    case (state_q)
      RUN:     if (accept && last_i && total > lanes_p) state_n = FLUSH;
      FLUSH:   if (out_free) state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  // Handshake outputs; ready only depends on state and the consumer.
  always_comb begin
    out_free   = ~v_q | yumi_i;
    ready_o    = (state_q == RUN) & out_free;
    flush_emit = (state_q == FLUSH) & out_free;
    accept     = v_i & ready_o;
  end

  // Output register and residue update; residue lanes beyond occ are kept zero.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q     <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
      occ_q   <= '0;
      for (int j = 0; j < lanes_p-1; j++) res_q[j] <= '0;
    end else if (flush_emit) begin
      v_q     <= 1'b1;
      data_q  <= res_flat;
      count_q <= occ_q;
      last_q  <= 1'b1;
      occ_q   <= '0;
      for (int j = 0; j < lanes_p-1; j++) res_q[j] <= '0;
    end else if (accept) begin
      if (total >= lanes_p) begin
        v_q     <= 1'b1;
        count_q <= cw_lp'(lanes_p);
        last_q  <= last_i & (total == lanes_p);
        occ_q   <= cw_lp'(total - lanes_p);
        for (int j = 0; j < lanes_p; j++)   data_q[j*width_p +: width_p] <= merged[j];
        for (int j = 0; j < lanes_p-1; j++) res_q[j] <= merged[j+lanes_p];
      end else if (last_i) begin
        v_q     <= 1'b1;
        count_q <= cw_lp'(total);
        last_q  <= 1'b1;
        occ_q   <= '0;
        for (int j = 0; j < lanes_p; j++)   data_q[j*width_p +: width_p] <= merged[j];
        for (int j = 0; j < lanes_p-1; j++) res_q[j] <= '0;
      end else begin
        v_q   <= 1'b0;
        occ_q <= cw_lp'(total);
        for (int j = 0; j < lanes_p-1; j++) res_q[j] <= merged[j];
      end
    end else if (yumi_i) begin
      v_q <= 1'b0;
    end
  end

  // Sanity check that the forward map agrees with the compacted lanes.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && accept) begin
      for (int j = 0; j < lanes_p; j++) begin
        if (j < int'(comp_count))
          assert (comp_data[j*width_p +: width_p] ==
                  data_i[int'(src_idx[j*iw_lp +: iw_lp])*width_p +: width_p]);
      end
    end
  end

  assign v_o     = v_q;
  assign data_o  = data_q;
  assign count_o = count_q;
  assign last_o  = last_q;

endmodule

// File: tb/tb_bsg_scatter_gather_packer.sv
// Directed vector bench for the scatter/gather lane packer (4 lanes x 8 bits).
module tb_bsg_scatter_gather_packer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        v_i = 1'b0;
  logic        ready_o;
  logic [31:0] data_i = '0;
  logic [3:0]  mask_i = '0;
  logic        last_i = 1'b0;
  logic        v_o;
  logic        yumi_i = 1'b0;
  logic [31:0] data_o;
  logic [2:0]  count_o;
  logic        last_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bsg_scatter_gather_packer #(
    .lanes_p(4),
    .width_p(8)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .v_i      (v_i),
    .ready_o  (ready_o),
    .data_i   (data_i),
    .mask_i   (mask_i),
    .last_i   (last_i),
    .v_o      (v_o),
    .yumi_i   (yumi_i),
    .data_o   (data_o),
    .count_o  (count_o),
    .last_o   (last_o)
  );

  typedef struct {
    logic        v;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        last;
    logic        yumi;
    logic        exp_ready;
    logic        exp_v;
    logic [31:0] exp_data;
    logic [2:0]  exp_count;
    logic        exp_last;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(logic v, logic [3:0] mask, logic [31:0] data, logic last,
                              logic yumi, logic exp_ready, logic exp_v,
                              logic [31:0] exp_data, logic [2:0] exp_count, logic exp_last);
    vec_t r;
    r.v = v; r.mask = mask; r.data = data; r.last = last; r.yumi = yumi;
    r.exp_ready = exp_ready; r.exp_v = exp_v; r.exp_data = exp_data;
    r.exp_count = exp_count; r.exp_last = exp_last;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] mask, input logic [31:0] data,
                       input logic last, input logic yumi);
    v_i = v; mask_i = mask; data_i = data; last_i = last; yumi_i = yumi;
  endtask

  initial begin
    //            v  mask  data          last yumi rdy  ev  exp_data      cnt  elast
    vecs[0]  = mk(1, 4'hF, 32'h13121110, 0,   1,   1,   1,  32'h13121110, 4,   0); // full beat
    vecs[1]  = mk(1, 4'h5, 32'hEE0CEE0A, 0,   1,   1,   0,  32'h0,        0,   0); // merge part 1
    vecs[2]  = mk(1, 4'hA, 32'h1DEE1BEE, 0,   1,   1,   1,  32'h1D1B0C0A, 4,   0); // merge part 2
    vecs[3]  = mk(1, 4'h7, 32'hFF030201, 0,   1,   1,   0,  32'h0,        0,   0); // overflow setup
    vecs[4]  = mk(1, 4'hF, 32'h07060504, 1,   1,   1,   1,  32'h04030201, 4,   0); // overflow last
    vecs[5]  = mk(1, 4'hF, 32'h99999999, 0,   1,   0,   1,  32'h00070605, 3,   1); // flush bubble
    vecs[6]  = mk(1, 4'hF, 32'h23222120, 0,   1,   1,   1,  32'h23222120, 4,   0); // backpressure setup
    vecs[7]  = mk(1, 4'hF, 32'h33333333, 0,   0,   0,   1,  32'h23222120, 4,   0); // stall 1
    vecs[8]  = mk(1, 4'hF, 32'h33333333, 0,   0,   0,   1,  32'h23222120, 4,   0); // stall 2
    vecs[9]  = mk(1, 4'hF, 32'h33333333, 0,   0,   0,   1,  32'h23222120, 4,   0); // stall 3
    vecs[10] = mk(0, 4'h0, 32'h0,        0,   1,   1,   0,  32'h0,        0,   0); // drain
    vecs[11] = mk(1, 4'h0, 32'hAAAAAAAA, 1,   0,   1,   1,  32'h0,        0,   1); // empty last
    vecs[12] = mk(0, 4'h0, 32'h0,        0,   1,   1,   0,  32'h0,        0,   0); // drain
    vecs[13] = mk(1, 4'h2, 32'h00005100, 0,   1,   1,   0,  32'h0,        0,   0); // residue 1 lane
    vecs[14] = mk(1, 4'h9, 32'h63000060, 1,   1,   1,   1,  32'h00636051, 3,   1); // partial last
    vecs[15] = mk(1, 4'h3, 32'h00007170, 0,   1,   1,   0,  32'h0,        0,   0); // residue 2 lanes
    vecs[16] = mk(1, 4'hC, 32'h73720000, 1,   1,   1,   1,  32'h73727170, 4,   1); // exact fill last
    vecs[17] = mk(1, 4'hF, 32'h83828180, 0,   1,   1,   1,  32'h83828180, 4,   0); // no flush after exact
    vecs[18] = mk(0, 4'h0, 32'h0,        0,   1,   1,   0,  32'h0,        0,   0); // drain

    // Reset held with random inputs.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(1'($urandom), 4'($urandom), $urandom, 1'($urandom), 1'($urandom));
      #1;
      chk("reset_v", 32'(v_o), 32'h0);
      chk("reset_count", 32'(count_o), 32'h0);
      chk("reset_last", 32'(last_o), 32'h0);
      chk("reset_data", data_o, 32'h0);
    end
    @(negedge clk);
    drive(0, 4'h0, 32'h0, 0, 0);
    reset_n = 1'b1;
    #1;
    chk("ready_after_reset", 32'(ready_o), 32'h1);

    // Table-driven vectors.
    @(negedge clk);
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].v, vecs[i].mask, vecs[i].data, vecs[i].last, vecs[i].yumi);
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(ready_o), 32'(vecs[i].exp_ready));
      @(negedge clk);
      chk($sformatf("vec%0d_v", i), 32'(v_o), 32'(vecs[i].exp_v));
      if (vecs[i].exp_v) begin
        chk($sformatf("vec%0d_data", i), data_o, vecs[i].exp_data);
        chk($sformatf("vec%0d_count", i), 32'(count_o), 32'(vecs[i].exp_count));
        chk($sformatf("vec%0d_last", i), 32'(last_o), 32'(vecs[i].exp_last));
      end
    end

    // Reset in the middle of a packet with residue and a pending beat.
    drive(1, 4'h7, 32'h00030201, 0, 0);
    @(negedge clk);
    drive(1, 4'hF, 32'h07060504, 0, 0);
    @(negedge clk);
    chk("midrst_pending_v", 32'(v_o), 32'h1);
    chk("midrst_pending_data", data_o, 32'h04030201);
    drive(0, 4'h0, 32'h0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_async_v", 32'(v_o), 32'h0);
    chk("midrst_async_count", 32'(count_o), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("midrst_ready", 32'(ready_o), 32'h1);
    drive(1, 4'hF, 32'h93929190, 1, 0);
    @(negedge clk);
    chk("midrst_fresh_v", 32'(v_o), 32'h1);
    chk("midrst_fresh_data", data_o, 32'h93929190);
    chk("midrst_fresh_count", 32'(count_o), 32'h4);
    chk("midrst_fresh_last", 32'(last_o), 32'h1);
    drive(0, 4'h0, 32'h0, 0, 1);
    @(negedge clk);
    chk("midrst_drain_v", 32'(v_o), 32'h0);
    #1;
    chk("midrst_drain_ready", 32'(ready_o), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_scatter_gather_packer.md
# bsg_scatter_gather_packer

Streaming, parametrised lane compactor: each accepted beat carries `lanes_p` data lanes plus a per-lane valid mask. The block gathers the valid lanes in ascending lane order, merges them with a residue of previously accepted lanes, and emits dense beats of exactly `lanes_p` lanes, with a partial beat at packet end. It sits between sparse producers (scatter/filter stages) and dense consumers (FIFOs, memory writers). It supersedes purely combinational, fixed-width scatter/gather index generation.

## Interface
Parameters:
- `lanes_p`, 4, lanes per beat; ≥2.
- `width_p`, 8, bits per lane.

Ports:
- `clk_i` in 1: clock.
- `reset_n_i` in 1: reset; asynchronous, active-low.
- `v_i` in 1: input beat valid.
- `ready_o` out 1: block can accept this cycle.
- `data_i` in `lanes_p*width_p`: lane i at bits `[i*width_p +: width_p]`.
- `mask_i` in `lanes_p`: per-lane valid.
- `last_i` in 1: final beat of packet; forces flush.
- `v_o` out 1: output beat valid.
- `yumi_i` in 1: consumer takes the output beat; legal only while `v_o`=1.
- `data_o` out `lanes_p*width_p`: dense lanes, lane 0 oldest; unused lanes are 0.
- `count_o` out `$clog2(lanes_p+1)`: number of valid lanes in `data_o`.
- `last_o` out 1: beat closes the packet.

## Operation
- Input transfer: `v_i & ready_o`. Output transfer: `v_o & yumi_i`.
- State: `occ` residue count (0..`lanes_p-1`), residue store (`lanes_p-1` lanes), single-entry output register, FSM {RUN, FLUSH}.
- `ready_o` = (state==RUN) & (~`v_o` | `yumi_i`). It is combinational from state and `yumi_i`. It must not depend on `v_i`.
- On accept: k = popcount(`mask_i`). Compact the masked lanes in ascending index order. total = `occ` + k. The merged order is residue lanes first, then compacted input lanes.
  - total ≥ `lanes_p`: load the output register with the first `lanes_p` merged lanes, `count_o`=`lanes_p`. The new residue is the remaining total−`lanes_p` lanes.
    - If `last_i`=1 and the remainder is 0: set `last_o`=1.
    - If `last_i`=1 and the remainder is >0: set `last_o`=0 and go to FLUSH.
  - total < `lanes_p`, `last_i`=0: store all lanes in the residue, `occ`=total. No output beat.
  - total < `lanes_p`, `last_i`=1: emit a partial beat with `count_o`=total and `last_o`=1, then clear `occ`. total=0 still emits a beat with `count_o`=0 and `last_o`=1.
- FLUSH: `ready_o`=0. When the output register is free or being consumed, emit the residue with `count_o`=`occ` and `last_o`=1. Then clear `occ` and return to RUN.
- The output register holds its value while `v_o` & ~`yumi_i`. No beat may be dropped or duplicated.
- `yumi_i` asserted without `v_o`: ignored.

## Timing
- Latency: 1 cycle from input transfer to `v_o` of the resulting beat.
- Throughput: 1 beat/cycle while `yumi_i` is held. FLUSH adds exactly one bubble cycle on the input side.
- Reset (async assert, sync-safe deassert): `v_o`=0, `data_o`=0, `count_o`=0, `last_o`=0, `occ`=0, state RUN. `ready_o`=1 once reset is released.
- Reset mid-packet discards the residue and any pending output beat.

## Structure
- Package `bsg_scatter_gather_pkg`: FSM state enum {RUN, FLUSH} and the count-width function `$clog2(lanes_p+1)`.
- Sub-module `bsg_compact_lanes`: combinational prefix-sum compactor, parametrised by `lanes_p` and `width_p`. Outputs: compacted lanes, popcount, and the per-output-lane source index (forward map). The packer instantiates it once.
- The top-level holds the residue, the merge shifter, the output register and the FSM.

## Test plan
All cases use `lanes_p`=4, `width_p`=8.
- Reset: hold `reset_n_i`=0 with random inputs → `v_o`=0, `count_o`=0. After release, `ready_o`=1.
- Full beat: mask 1111, lanes {0x10,0x11,0x12,0x13} → next cycle `data_o` lanes {10,11,12,13}, `count_o`=4, `last_o`=0.
- Merge across beats: mask 0101 with lane0=0x0A, lane2=0x0C → no output. Then mask 1010 with lane1=0x1B, lane3=0x1D → beat {0A,0C,1B,1D}, `count_o`=4.
- Overflow flush: mask 0111 with {1,2,3} → no output. Then mask 1111 with {4,5,6,7}, `last_i`=1 → beat {1,2,3,4} with `count_o`=4, `last_o`=0, and `ready_o`=0 for one cycle. Next beat {5,6,7,0}, `count_o`=3, `last_o`=1.
- Backpressure: hold `yumi_i`=0 for 3 cycles with `v_o`=1 → `data_o`, `count_o` and `last_o` stay stable, `ready_o`=0, and nothing is lost after `yumi_i` rises.
- Empty last: `occ`=0, mask 0000, `last_i`=1 → one beat with `count_o`=0, `last_o`=1, `data_o`=0.
